multicycle_main_controller: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It is the producer of the 2-bit ALUop bus that the ALU control decoder consumes, using the same encoding: 00 add, 01 sub, 10 R-type (decoder uses func), 11 slt.

---
 rtl/mips_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_output_decode.sv | 94 +++++++++
 rtl/multicycle_main_controller.sv | 129 ++++++++++++
 tb/tb_multicycle_main_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control path.
//   - opcode constants (instr[31:26])
//   - ALUop encoding, shared with the ALU control decoder
//   - ALUSrcB / PCSource select encodings
//   - 13-state main FSM encoding (4 bits)
//   - control word struct produced by mc_output_decode
//   - op_is_defined(): true for opcodes the controller implements
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // ALUop encoding consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_SLT  = 2'b11;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_SLTIEX = 4'd11,
        S_IWB    = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_is_defined(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_J, OP_ADDI, OP_SLTI: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// -----------------------------------------------------------------------------
// mc_output_decode
// Combinational decode of the main FSM state into the datapath control word.
// Ports:
//   state_i    : current FSM state
//   op_undef_i : opcode in IR is outside the supported instruction set (only
//                matters in DECODE, where it makes DECODE the last state of
//                the instruction)
//   ctrl_o     : control word; every field not set for a state is 0
// -----------------------------------------------------------------------------
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   op_undef_i,
    output ctrl_t  ctrl_o
);

    // State -> control word; defaults first, then per-state overrides.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                ctrl_o.alu_src_b  = SRCB_IMMSH2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.instr_done = op_undef_i;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_REXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_SLTIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_SLT;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// multicycle_main_controller
// Main control FSM of the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives all
// datapath enables and mux selects.
// Ports:
//   clk, rst      : clock (rising edge), async active-high reset
//   opcode        : instr[31:26] from IR, used in DECODE and MEMADR
//   zero          : ALU zero flag (the datapath qualifies PCWriteCond with it)
//   PCWrite .. PCSource : datapath control, see mc_output_decode
//   instr_done    : pulse in the last state of each instruction
//   state_dbg     : current state encoding
// -----------------------------------------------------------------------------
module multicycle_main_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic [1:0]          PCSource,
    output logic                instr_done,
    output logic [3:0]          state_dbg
);

    state_e state_q;
    state_e state_d;
    // Set by reset and cleared by the first clock edge after release, so the
    // first FETCH strobes only appear in the cycle following deassertion.
    logic   hold_q;
    logic   gate_s;
    logic   op_undef_s;
    ctrl_t  ctrl_s;

    // The branch outcome is resolved in the datapath, not here.
    logic   unused_zero_s;
    assign unused_zero_s = zero;

    assign op_undef_s = ~op_is_defined(opcode[5:0]);

    // State register with asynchronous reset to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        if (hold_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (opcode[5:0])
                        OP_RTYPE:     state_d = S_REXEC;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_SLTI:      state_d = S_SLTIEX;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode[5:0] == OP_LW) begin
                        state_d = S_MEMRD;
                    end else begin
                        state_d = S_MEMWR;
                    end
                end
                S_MEMRD:  state_d = S_MEMWB;
                S_REXEC:  state_d = S_RWB;
                S_ADDIEX: state_d = S_IWB;
                S_SLTIEX: state_d = S_IWB;
                S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_JUMP, S_IWB: state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state_i    (state_q),
        .op_undef_i (op_undef_s),
        .ctrl_o     (ctrl_s)
    );

    // Strobes are suppressed while reset is held and until the release edge;
    // mux selects simply show the FETCH decode during that time.
    assign gate_s = rst | hold_q;

    assign PCWrite     = ctrl_s.pc_write      & ~gate_s;
    assign PCWriteCond = ctrl_s.pc_write_cond & ~gate_s;
    assign MemRead     = ctrl_s.mem_read      & ~gate_s;
    assign MemWrite    = ctrl_s.mem_write     & ~gate_s;
    assign IRWrite     = ctrl_s.ir_write      & ~gate_s;
    assign RegWrite    = ctrl_s.reg_write     & ~gate_s;
    assign instr_done  = ctrl_s.instr_done    & ~gate_s;
    assign IorD        = ctrl_s.iord;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign RegDst      = ctrl_s.reg_dst;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign ALUop       = ALUOP_W'(ctrl_s.alu_op);
    assign PCSource    = ctrl_s.pc_source;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multicycle_main_controller. Control outputs are
// packed into a 17-bit word:
// {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
//  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUop[1:0],PCSource[1:0],instr_done}
// -----------------------------------------------------------------------------
module tb_multicycle_main_controller;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_main_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .instr_done(instr_done), .state_dbg(state_dbg)
    );

    logic [16:0] act_w;
    assign act_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
                    PCSource, instr_done};

    function automatic logic [16:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] psrc, input logic done);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done};
    endfunction

    // Instruction-level reference: cycle count by instruction class.
    function automatic int ref_len(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b000000,
            6'b001000, 6'b001010:            return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    // Instruction-level reference: expected control word in cycle k (0 = fetch).
    function automatic logic [16:0] ref_word(input logic [5:0] op, input int k);
        logic [16:0] w;
        w = '0;
        if (k == 0) begin
            w = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
        end else if (k == 1) begin
            w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,
                   (ref_len(op) == 2));
        end else begin
            case (op)
                6'b100011: begin
                    if (k == 2)      w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
                    else if (k == 3) w = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
                    else             w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1);
                end
                6'b101011: begin
                    if (k == 2) w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
                    else        w = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1);
                end
                6'b000000: begin
                    if (k == 2) w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0);
                    else        w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1);
                end
                6'b001000, 6'b001010: begin
                    if (k == 2) w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,
                                       (op == 6'b001010) ? 2'b11 : 2'b00, 2'b00, 1'b0);
                    else        w = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1);
                end
                6'b000100: w = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1);
                6'b000010: w = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1);
                default:   w = '0;
            endcase
        end
        return w;
    endfunction

    // Outputs while reset holds: no strobes, FETCH mux selects.
    localparam logic [16:0] RESET_W = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int obs_rw, obs_mw, obs_done;

    // Run one instruction starting in FETCH, checking every cycle.
    task automatic run_instr(input logic [5:0] op, input logic z, input int len);
        obs_rw = 0; obs_mw = 0; obs_done = 0;
        for (int k = 0; k < len; k++) begin
            opcode = op;
            zero   = z;
            @(negedge clk);
            if (k == 0) check("fetch_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
            check($sformatf("op%b_cyc%0d", op, k), {15'd0, act_w}, {15'd0, ref_word(op, k)});
            obs_rw   += int'(RegWrite);
            obs_mw   += int'(MemWrite);
            obs_done += int'(instr_done);
            @(posedge clk);
            #1;
        end
    endtask

    // Release reset just after an edge; strobes stay off until the next edge.
    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("release_gap", {15'd0, act_w}, {15'd0, RESET_W});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         len;
        int         n_rw;
        int         n_mw;
    } vec_t;

    vec_t vt[10];
    logic [5:0] legal_ops[7];

    initial begin
        vt[0] = '{6'b100011, 1'b0, 5, 1, 0};   // lw
        vt[1] = '{6'b000000, 1'b1, 4, 1, 0};   // R-type
        vt[2] = '{6'b000100, 1'b0, 3, 0, 0};   // beq, zero=0
        vt[3] = '{6'b000100, 1'b1, 3, 0, 0};   // beq, zero=1
        vt[4] = '{6'b001010, 1'b0, 4, 1, 0};   // slti
        vt[5] = '{6'b001000, 1'b1, 4, 1, 0};   // addi
        vt[6] = '{6'b000010, 1'b0, 3, 0, 0};   // j
        vt[7] = '{6'b101011, 1'b0, 4, 0, 1};   // sw
        vt[8] = '{6'b111111, 1'b0, 2, 0, 0};   // undefined
        vt[9] = '{6'b000001, 1'b1, 2, 0, 0};   // undefined
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001000, 6'b001010};

        rst = 1'b1; opcode = 6'b000000; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_word", {15'd0, act_w}, {15'd0, RESET_W});
        check("reset_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
        release_reset();

        // Table-driven instructions, back to back.
        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].z, vt[i].len);
            check($sformatf("v%0d_regwrites", i), obs_rw, vt[i].n_rw);
            check($sformatf("v%0d_memwrites", i), obs_mw, vt[i].n_mw);
            check($sformatf("v%0d_done", i), obs_done, 1);
        end

        // Reset asserted in the middle of REXEC.
        opcode = 6'b000000;
        @(posedge clk); #1;           // now in DECODE
        @(posedge clk); #1;           // now in REXEC
        #2 rst = 1'b1;
        #1;
        check("midrst_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
        check("midrst_word", {15'd0, act_w}, {15'd0, RESET_W});
        @(posedge clk); #1;
        check("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
        release_reset();
        run_instr(6'b100011, 1'b0, 5);

        // BEQ: zero toggled inside the BEQ cycle must not change outputs.
        opcode = 6'b000100;
        @(posedge clk); #1;           // DECODE
        @(posedge clk); #1;           // BEQ
        zero = 1'b0; #1;
        check("beq_zero0", {15'd0, act_w}, {15'd0, ref_word(6'b000100, 2)});
        zero = 1'b1; #1;
        check("beq_zero1", {15'd0, act_w}, {15'd0, ref_word(6'b000100, 2)});
        @(posedge clk); #1;

        // Randomized instruction stream against the reference.
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7) op = legal_ops[sel];
            else         op = 6'($urandom_range(0, 63));
            run_instr(op, 1'($urandom_range(0, 1)), ref_len(op));
            check("rand_done", obs_done, 1);
        end

        @(negedge clk);
        check("final_state", {28'd0, state_dbg}, {28'd0, S_FETCH});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
